ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/ball_motion.sv | 203 ++++++++++++++++++++
 tb/tb_ball_motion.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: moves a square ball across a playfield once per frame,
// bouncing off the side and top walls, the paddle and bricks, and detecting
// when the ball falls past the paddle.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   frame_tick   one-cycle pulse, one position update per pulse while running
//   game_status  00 Idle, 01 Start, 10 Pause, 11 treated as Pause
//   paddle_x     paddle left column
//   brick_hit    brick-collision flag from the brick map, valid with frame_tick
//   ball_x/y     ball top-left corner (registered)
//   strike_board one-cycle pulse after a paddle bounce
//   strike_brick one-cycle pulse after a brick bounce
//   fall_down    one-cycle pulse when the ball reaches the bottom
//
// Optional feature: define BALL_SPEEDUP_EN to raise the step by one pixel on
// every 8th paddle hit (up to STEP+2); the step returns to STEP on serve.
module ball_motion #(
    parameter int unsigned H_MAX     = 640,
    parameter int unsigned V_MAX     = 480,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PADDLE_Y  = 440,
    parameter int unsigned PADDLE_W  = 64,
    parameter int unsigned START_X   = 316,
    parameter int unsigned START_Y   = 300,
    parameter int unsigned STEP      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [1:0] game_status,
    input  logic [9:0] paddle_x,
    input  logic       brick_hit,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       strike_board,
    output logic       strike_brick,
    output logic       fall_down
);

    typedef enum logic [1:0] {SERVE, RUN, FALLEN} state_t;

    localparam logic [1:0]  GS_IDLE  = 2'b00;
    localparam logic [1:0]  GS_START = 2'b01;
    localparam logic [10:0] X_LIM    = 11'(H_MAX - BALL_SIZE);
    localparam logic [10:0] Y_LIM    = 11'(V_MAX - BALL_SIZE);
    localparam logic [10:0] Y_PAD    = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] PAD_Y    = 11'(PADDLE_Y);
    localparam logic [10:0] BSZ      = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_W    = 11'(PADDLE_W);
    localparam logic [9:0]  X0       = 10'(START_X);
    localparam logic [9:0]  Y0       = 10'(START_Y);
    localparam logic [10:0] STEP0    = 11'(STEP);

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       dx_q, dx_d;              // 1: moving right
    logic       dy_q, dy_d;              // 1: moving down
    logic       board_q, board_d, brick_q, brick_d, fall_q, fall_d;

    logic [10:0] x11, y11, px11, step;
    logic [10:0] x_sum, y_sum;
    logic        paddle_hit, load_serve;

`ifdef BALL_SPEEDUP_EN
    localparam logic [10:0] STEP_MAX = 11'(STEP + 2);
    logic [10:0] step_q, step_d;
    logic [2:0]  hits_q, hits_d;
    assign step = step_q;
`else
    assign step = STEP0;
`endif

    assign x11   = {1'b0, x_q};
    assign y11   = {1'b0, y_q};
    assign px11  = {1'b0, paddle_x};
    assign x_sum = x11 + step;
    assign y_sum = y11 + step;

    // Paddle test uses the pre-move position: the ball must be fully above
    // the paddle now and reach its top row within this step.
    assign paddle_hit = dy_q && (y11 + BSZ <= PAD_Y) && (y_sum + BSZ >= PAD_Y)
                        && (x11 + BSZ > px11) && (x11 < px11 + PAD_W);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        board_d    = 1'b0;
        brick_d    = 1'b0;
        fall_d     = 1'b0;
        load_serve = 1'b0;
`ifdef BALL_SPEEDUP_EN
        step_d     = step_q;
        hits_d     = hits_q;
`endif
        unique case (state_q)
            SERVE: if (game_status == GS_START) state_d = RUN;
            RUN: begin
                if (game_status == GS_IDLE) begin
                    load_serve = 1'b1;
                end else if (game_status == GS_START && frame_tick) begin
                    if (dx_q) begin
                        if (x_sum >= X_LIM) begin
                            x_d  = X_LIM[9:0];
                            dx_d = 1'b0;
                        end else begin
                            x_d = x_sum[9:0];
                        end
                    end else if (x11 <= step) begin
                        x_d  = '0;
                        dx_d = 1'b1;
                    end else begin
                        x_d = 10'(x11 - step);
                    end

                    if (paddle_hit) begin
                        y_d     = Y_PAD[9:0];
                        dy_d    = 1'b0;
                        board_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        hits_d = hits_q + 3'd1;
                        if (hits_q == 3'd7 && step_q < STEP_MAX) step_d = step_q + 11'd1;
`endif
                    end else if (dy_q && y_sum >= Y_LIM) begin
                        y_d     = Y_LIM[9:0];
                        fall_d  = 1'b1;
                        state_d = FALLEN;
                    end else begin
                        if (dy_q) begin
                            y_d = y_sum[9:0];
                        end else if (y11 <= step) begin
                            y_d  = '0;
                            dy_d = 1'b1;
                        end else begin
                            y_d = 10'(y11 - step);
                        end
                        // Inverting the pre-move direction also agrees with
                        // a simultaneous top-wall bounce (both give down).
                        if (brick_hit) begin
                            dy_d    = ~dy_q;
                            brick_d = 1'b1;
                        end
                    end
                end
            end
            FALLEN: if (game_status == GS_IDLE) load_serve = 1'b1;
            default: load_serve = 1'b1;
        endcase

        if (load_serve) begin
            state_d = SERVE;
            x_d     = X0;
            y_d     = Y0;
            dx_d    = 1'b1;
            dy_d    = 1'b0;
`ifdef BALL_SPEEDUP_EN
            step_d  = STEP0;
            hits_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SERVE;
            x_q     <= X0;
            y_q     <= Y0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b0;
            board_q <= 1'b0;
            brick_q <= 1'b0;
            fall_q  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            step_q  <= STEP0;
            hits_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            board_q <= board_d;
            brick_q <= brick_d;
            fall_q  <= fall_d;
`ifdef BALL_SPEEDUP_EN
            step_q  <= step_d;
            hits_q  <= hits_d;
`endif
        end
    end

    assign ball_x       = x_q;
    assign ball_y       = y_q;
    assign strike_board = board_q;
    assign strike_brick = brick_q;
    assign fall_down    = fall_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: an integer-arithmetic model of the ball rules is
// compared with the DUT every cycle, and directed episodes pin known points
// of the trajectory (first move, wall/top bounces, paddle, fall, brick, pause).
module tb_ball_motion;

    localparam int HM = 640, VM = 480, BS = 8, PY = 440, PW = 64;
    localparam int SX = 316, SY = 300, ST = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] game_status = 2'b00;
    logic [9:0] paddle_x = 10'd0;
    logic       brick_hit = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic       strike_board, strike_brick, fall_down;

    int n_checks = 0;
    int n_fail = 0;

    ball_motion #(.H_MAX(HM), .V_MAX(VM), .BALL_SIZE(BS), .PADDLE_Y(PY),
                  .PADDLE_W(PW), .START_X(SX), .START_Y(SY), .STEP(ST)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .game_status(game_status), .paddle_x(paddle_x), .brick_hit(brick_hit),
        .ball_x(ball_x), .ball_y(ball_y), .strike_board(strike_board),
        .strike_brick(strike_brick), .fall_down(fall_down)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mx = SX, my = SY, mvx = 1, mvy = -1, mstep = ST, mhits = 0;
    bit mrun = 0, mfallen = 0;
    bit eb = 0, ek = 0, ef = 0;

    task automatic serve();
        mx = SX; my = SY; mvx = 1; mvy = -1;
        mrun = 0; mfallen = 0; mstep = ST; mhits = 0;
    endtask

    task automatic move(input int px, input bit brick);
        int nx, ny, old_vy;
        bit pad;
        nx = mx + mvx * mstep;
        if (nx >= HM - BS) begin nx = HM - BS; mvx = -1; end
        else if (nx <= 0) begin nx = 0; mvx = 1; end
        old_vy = mvy;
        ny = my + mvy * mstep;
        pad = (mvy > 0) && (my + BS <= PY) && (ny + BS >= PY) &&
              (mx + BS > px) && (mx < px + PW);
        if (pad) begin
            ny = PY - BS; mvy = -1; eb = 1;
`ifdef BALL_SPEEDUP_EN
            mhits++;
            if (mhits == 8) begin
                mhits = 0;
                if (mstep < ST + 2) mstep++;
            end
`endif
        end else if (mvy > 0 && ny >= VM - BS) begin
            ny = VM - BS; ef = 1; mfallen = 1; mrun = 0;
        end else begin
            if (mvy < 0 && ny <= 0) begin ny = 0; mvy = 1; end
            if (brick) begin mvy = -old_vy; ek = 1; end
        end
        mx = nx; my = ny;
    endtask

    always @(posedge clk) begin
        eb = 0; ek = 0; ef = 0;
        if (!rst_n) serve();
        else if (mfallen) begin
            if (game_status == 2'b00) serve();
        end else if (!mrun) begin
            if (game_status == 2'b01) mrun = 1;
        end else if (game_status == 2'b00) serve();
        else if (game_status == 2'b01 && frame_tick) move(int'(paddle_x), brick_hit);
    end

    // One compare per cycle: position and all three pulses.
    always @(negedge clk) begin
        n_checks++;
        if (ball_x != 10'(mx) || ball_y != 10'(my) || strike_board != eb ||
            strike_brick != ek || fall_down != ef) begin
            n_fail++;
            $display("FAIL model t=%0t got x=%0d y=%0d b=%0d k=%0d f=%0d want x=%0d y=%0d b=%0d k=%0d f=%0d",
                     $time, ball_x, ball_y, strike_board, strike_brick, fall_down,
                     mx, my, eb, ek, ef);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; frame_tick = 1'b0; game_status = 2'b00; brick_hit = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        // Episode 1: walls, top and paddle bounce.
        do_reset();
        chk("reset_x", int'(ball_x), 316);
        chk("reset_y", int'(ball_y), 300);
        chk("reset_pulses", int'({strike_board, strike_brick, fall_down}), 0);
        paddle_x = 10'd200;
        @(negedge clk); game_status = 2'b01;
        tick();
        chk("first_x", int'(ball_x), 318);
        chk("first_y", int'(ball_y), 298);
        chk("first_pulses", int'({strike_board, strike_brick, fall_down}), 0);
        ticks(149);
        chk("top_y", int'(ball_y), 0);
        chk("top_x", int'(ball_x), 616);
        ticks(8);
        chk("right_x", int'(ball_x), 632);
        tick();
        chk("right_back_x", int'(ball_x), 630);
        chk("right_back_y", int'(ball_y), 18);
        ticks(207);
        chk("paddle_y", int'(ball_y), 432);
        chk("paddle_x", int'(ball_x), 216);
        chk("paddle_pulse", int'(strike_board), 1);
        @(negedge clk);
        chk("paddle_pulse_end", int'(strike_board), 0);
        tick();
        chk("paddle_up_y", int'(ball_y), 430);

        // Episode 2: miss the paddle and fall.
        do_reset();
        paddle_x = 10'd600;
        @(negedge clk); game_status = 2'b01;
        ticks(386);
        chk("fall_y", int'(ball_y), 472);
        chk("fall_x", int'(ball_x), 176);
        chk("fall_pulse", int'(fall_down), 1);
        @(negedge clk);
        chk("fall_pulse_end", int'(fall_down), 0);
        ticks(3);
        chk("fallen_frozen", int'({ball_x, ball_y}), (176 << 10) | 472);
        chk("fallen_no_repulse", int'(fall_down), 0);
        @(negedge clk); game_status = 2'b00;
        @(negedge clk);
        chk("reserve_x", int'(ball_x), 316);
        chk("reserve_y", int'(ball_y), 300);

        // Episode 3: brick bounce, pause, mid-run reset.
        @(negedge clk); game_status = 2'b01; brick_hit = 1'b1;
        tick();
        brick_hit = 1'b0;
        chk("brick_y", int'(ball_y), 298);
        chk("brick_pulse", int'(strike_brick), 1);
        tick();
        chk("brick_down_y", int'(ball_y), 300);
        chk("brick_down_x", int'(ball_x), 320);
        chk("brick_pulse_end", int'(strike_brick), 0);
        game_status = 2'b10;
        ticks(3);
        chk("pause_pos", int'({ball_x, ball_y}), (320 << 10) | 300);
        game_status = 2'b11;
        ticks(2);
        chk("pause11_pos", int'({ball_x, ball_y}), (320 << 10) | 300);
        game_status = 2'b01;
        tick();
        chk("resume_pos", int'({ball_x, ball_y}), (322 << 10) | 302);
        @(negedge clk); rst_n = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        chk("midrun_reset_pos", int'({ball_x, ball_y}), (316 << 10) | 300);
        rst_n = 1'b1; frame_tick = 1'b0;

        // Randomized phase, checked by the model every cycle.
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 2999) != 0);
            if ($urandom_range(0, 99) < 2) begin
                case ($urandom_range(0, 19))
                    0:       game_status = 2'b00;
                    1, 2:    game_status = 2'b10;
                    3:       game_status = 2'b11;
                    default: game_status = 2'b01;
                endcase
            end
            if (mfallen && $urandom_range(0, 49) == 0) game_status = 2'b00;
            frame_tick = ($urandom_range(0, 3) == 0);
            brick_hit  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 9) < 8) begin
                    int p;
                    p = mx - int'($urandom_range(0, 60));
                    paddle_x = (p < 0) ? 10'd0 : 10'(p);
                end else begin
                    paddle_x = 10'($urandom_range(0, 639));
                end
            end
        end
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
